// File: rtl/wb_two_slave_fabric_pkg.sv
// Shared constants and bus bundles for the two-slave Wishbone fabric.
// Slave select codes, GPIO register offsets and DRT word layout.
package wb_two_slave_fabric_pkg;

  localparam logic [7:0] SEL_DRT  = 8'h00;
  localparam logic [7:0] SEL_GPIO = 8'h01;

  localparam logic [23:0] GPIO_OUT      = 24'd0;
  localparam logic [23:0] GPIO_IN       = 24'd1;
  localparam logic [23:0] GPIO_INT_EN   = 24'd2;
  localparam logic [23:0] GPIO_INT_STAT = 24'd3;

  localparam logic [23:0] DRT_HDR   = 24'd0;
  localparam logic [23:0] DRT_RSVD  = 24'd1;
  localparam logic [23:0] DRT_ID    = 24'd4;
  localparam logic [23:0] DRT_FLAGS = 24'd5;
  localparam logic [23:0] DRT_BASE  = 24'd6;
  localparam logic [23:0] DRT_SIZE  = 24'd7;

  localparam logic [15:0] DRT_NUM_DEV = 16'd1;
  localparam logic [31:0] GPIO_BASE   = 32'h0100_0000;
  localparam logic [31:0] GPIO_WORDS  = 32'd4;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [23:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  typedef struct packed {
    logic        ack;
    logic [31:0] dat;
  } wb_rsp_t;

  localparam wb_req_t REQ_IDLE = '0;

endpackage

// File: rtl/wb_two_slave_fabric_gpio_regs.sv
// GPIO register block: OUT, synchronized IN, optional INT_EN/INT_STAT.
// Interrupt logic is present only when GPIO_INTERRUPT_EN is defined.
module wb_two_slave_fabric_gpio_regs
  import wb_two_slave_fabric_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  wb_req_t     req,
  output wb_rsp_t     rsp,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic        irq
);

  logic        acc;
  logic        wr;
  logic [31:0] out_q;
  logic [31:0] sync1;
  logic [31:0] sync2;
  logic [31:0] en_q;
  logic [31:0] stat_q;
  logic [31:0] rd;

  assign acc = req.cyc & req.stb & ~rsp.ack;
  assign wr  = acc & req.we;
  assign gpio_out = out_q;

  always_comb begin
    rd = '0;
    unique case (1'b1)
      (req.adr == GPIO_OUT):      rd = out_q;
      (req.adr == GPIO_IN):       rd = sync2;
      (req.adr == GPIO_INT_EN):   rd = en_q;
      (req.adr == GPIO_INT_STAT): rd = stat_q;
      default:                    rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp   <= '0;
      out_q <= '0;
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      rsp.ack <= acc;
      rsp.dat <= acc ? rd : '0;
      sync1   <= gpio_in;
      sync2   <= sync1;
      if (wr && req.adr == GPIO_OUT) out_q <= req.dat;
    end
  end

`ifdef GPIO_INTERRUPT_EN
  logic [31:0] prev_q;
  logic [31:0] clr;

  assign clr = (wr && req.adr == GPIO_INT_STAT) ? req.dat : '0;
  assign irq = |(stat_q & en_q);

  // Set wins over write-1-to-clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= '0;
      en_q   <= '0;
      stat_q <= '0;
    end else begin
      prev_q <= sync2;
      stat_q <= (stat_q & ~clr) | (en_q & (sync2 ^ prev_q));
      if (wr && req.adr == GPIO_INT_EN) en_q <= req.dat;
    end
  end
`else
  assign en_q   = '0;
  assign stat_q = '0;
  assign irq    = 1'b0;
`endif

endmodule

// File: rtl/wb_two_slave_fabric.sv
// Single-master Wishbone fabric: decoder, device ROM table, GPIO slave.
// Build option GPIO_INTERRUPT_EN enables the GPIO interrupt registers.
module wb_two_slave_fabric
  import wb_two_slave_fabric_pkg::*;
#(
  parameter logic [15:0] DRT_VERSION = 16'h0001,
  parameter logic [31:0] GPIO_DEV_ID = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_cyc_i,
  input  logic        m_stb_i,
  input  logic        m_we_i,
  input  logic [31:0] m_adr_i,
  input  logic [31:0] m_dat_i,
  output logic [31:0] m_dat_o,
  output logic        m_ack_o,
  output logic        m_int_o,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out
);

  wb_req_t     req;
  wb_req_t     drt_req;
  wb_req_t     gpio_req;
  wb_rsp_t     gpio_rsp;
  logic        um_sel;
  logic        um_ack;
  logic        drt_ack;
  logic [31:0] drt_dat;
  logic [31:0] drt_rd;
  logic        drt_acc;
  logic        drt_unused;

  assign req = '{cyc: m_cyc_i, stb: m_stb_i, we: m_we_i,
                 adr: m_adr_i[23:0], dat: m_dat_i};

  always_comb begin
    drt_req  = REQ_IDLE;
    gpio_req = REQ_IDLE;
    um_sel   = 1'b0;
    unique case (1'b1)
      (m_adr_i[31:24] == SEL_DRT):  drt_req  = req;
      (m_adr_i[31:24] == SEL_GPIO): gpio_req = req;
      default:                      um_sel   = 1'b1;
    endcase
  end

  always_comb begin
    drt_rd = '0;
    unique case (1'b1)
      (drt_req.adr == DRT_HDR):   drt_rd = {DRT_VERSION, DRT_NUM_DEV};
      (drt_req.adr == DRT_RSVD):  drt_rd = '0;
      (drt_req.adr == DRT_ID):    drt_rd = GPIO_DEV_ID;
      (drt_req.adr == DRT_FLAGS): drt_rd = '0;
      (drt_req.adr == DRT_BASE):  drt_rd = GPIO_BASE;
      (drt_req.adr == DRT_SIZE):  drt_rd = GPIO_WORDS;
      default:                    drt_rd = '0;
    endcase
  end

  // DRT is read-only: write enable and data are intentionally dropped.
  assign drt_unused = ^{drt_req.we, drt_req.dat};
  assign drt_acc = drt_req.cyc & drt_req.stb & ~drt_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drt_ack <= 1'b0;
      drt_dat <= '0;
      um_ack  <= 1'b0;
    end else begin
      drt_ack <= drt_acc;
      drt_dat <= drt_acc ? drt_rd : '0;
      um_ack  <= m_cyc_i & m_stb_i & um_sel & ~um_ack;
    end
  end

  wb_two_slave_fabric_gpio_regs u_gpio (
    .clk      (clk),
    .rst      (rst),
    .req      (gpio_req),
    .rsp      (gpio_rsp),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .irq      (m_int_o)
  );

  // Idle slaves hold ack and data at zero, so OR acts as the return mux.
  assign m_ack_o = drt_ack | gpio_rsp.ack | um_ack;
  assign m_dat_o = drt_dat | gpio_rsp.dat;

endmodule

// File: tb/tb_wb_two_slave_fabric.sv
// Directed-vector bench for wb_two_slave_fabric.
// Interrupt expectations follow the GPIO_INTERRUPT_EN build option.
module tb_wb_two_slave_fabric;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m_cyc_i = 1'b0;
  logic        m_stb_i = 1'b0;
  logic        m_we_i = 1'b0;
  logic [31:0] m_adr_i = '0;
  logic [31:0] m_dat_i = '0;
  logic [31:0] m_dat_o;
  logic        m_ack_o;
  logic        m_int_o;
  logic [31:0] gpio_in = '0;
  logic [31:0] gpio_out;

  int vecs = 0;
  int errs = 0;
  logic [31:0] q;

  always #5 clk = ~clk;

  wb_two_slave_fabric dut (
    .clk      (clk),
    .rst      (rst),
    .m_cyc_i  (m_cyc_i),
    .m_stb_i  (m_stb_i),
    .m_we_i   (m_we_i),
    .m_adr_i  (m_adr_i),
    .m_dat_i  (m_dat_i),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .m_int_o  (m_int_o),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] a, input logic w,
                      input logic [31:0] d, output logic [31:0] r);
    @(negedge clk);
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = w;
    m_adr_i = a; m_dat_i = d;
    @(posedge clk); #1;
    check("ack_hi", {31'd0, m_ack_o}, 32'd1);
    r = m_dat_o;
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
    @(posedge clk); #1;
    check("ack_lo", {31'd0, m_ack_o}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t drt_tab[5] = '{
    '{32'h0000_0000, 32'h0001_0001},
    '{32'h0000_0004, 32'h0000_0001},
    '{32'h0000_0006, 32'h0100_0000},
    '{32'h0000_0007, 32'h0000_0004},
    '{32'h0000_0009, 32'h0000_0000}
  };

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, m_ack_o}, 32'd0);
    check("rst_dat", m_dat_o, 32'd0);
    check("rst_out", gpio_out, 32'd0);
    check("rst_int", {31'd0, m_int_o}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Reset asserted while a GPIO write is being acknowledged.
    @(negedge clk);
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b1;
    m_adr_i = 32'h0100_0000; m_dat_i = 32'h1234_5678;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check("mid_rst_ack", {31'd0, m_ack_o}, 32'd0);
    check("mid_rst_out", gpio_out, 32'd0);
    check("mid_rst_int", {31'd0, m_int_o}, 32'd0);
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
    @(negedge clk); rst = 1'b1;

    xfer(32'h0100_0000, 1'b1, 32'hCAFE_BABE, q);
    check("gpio_out", gpio_out, 32'hCAFE_BABE);
    xfer(32'h0100_0000, 1'b0, 32'h0, q);
    check("out_rd", q, 32'hCAFE_BABE);

    gpio_in = 32'h0123_4567;
    repeat (3) @(posedge clk);
    xfer(32'h0100_0001, 1'b0, 32'h0, q);
    check("in_rd", q, 32'h0123_4567);
    xfer(32'h0100_0001, 1'b1, 32'hFFFF_FFFF, q);
    xfer(32'h0100_0001, 1'b0, 32'h0, q);
    check("in_ro", q, 32'h0123_4567);
    check("in_wr_out", gpio_out, 32'hCAFE_BABE);
    xfer(32'h0100_0005, 1'b0, 32'h0, q);
    check("gpio_hole", q, 32'h0);

    foreach (drt_tab[i]) begin
      xfer(drt_tab[i].adr, 1'b0, 32'h0, q);
      check($sformatf("drt_%0h", drt_tab[i].adr), q, drt_tab[i].exp);
    end
    xfer(32'h0000_0000, 1'b1, 32'hDEAD_BEEF, q);
    xfer(32'h0000_0000, 1'b0, 32'h0, q);
    check("drt_ro", q, 32'h0001_0001);

    xfer(32'h0500_0000, 1'b0, 32'h0, q);
    check("um_rd", q, 32'h0);
    xfer(32'h0500_0000, 1'b1, 32'h0000_FFFF, q);
    check("um_wr_out", gpio_out, 32'hCAFE_BABE);

    // Strobe held: ack, gap, ack.
    @(negedge clk);
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0;
    m_adr_i = 32'h0000_0006;
    @(posedge clk); #1;
    check("hold_ack1", {31'd0, m_ack_o}, 32'd1);
    check("hold_dat1", m_dat_o, 32'h0100_0000);
    @(posedge clk); #1;
    check("hold_gap", {31'd0, m_ack_o}, 32'd0);
    @(posedge clk); #1;
    check("hold_ack2", {31'd0, m_ack_o}, 32'd1);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(posedge clk); #1;
    check("hold_end", {31'd0, m_ack_o}, 32'd0);

    xfer(32'h0100_0002, 1'b1, 32'h0000_0001, q);
    xfer(32'h0100_0002, 1'b0, 32'h0, q);
`ifdef GPIO_INTERRUPT_EN
    check("int_en_rd", q, 32'h1);
`else
    check("int_en_rd", q, 32'h0);
`endif
    check("int_idle", {31'd0, m_int_o}, 32'd0);

    @(negedge clk); gpio_in[0] = ~gpio_in[0];
    repeat (2) @(posedge clk);
    #1;
    check("int_e2", {31'd0, m_int_o}, 32'd0);
    @(posedge clk); #1;
`ifdef GPIO_INTERRUPT_EN
    check("int_e3", {31'd0, m_int_o}, 32'd1);
    xfer(32'h0100_0003, 1'b0, 32'h0, q);
    check("stat_rd", q, 32'h1);
    xfer(32'h0100_0003, 1'b1, 32'h1, q);
    check("int_clr", {31'd0, m_int_o}, 32'd0);
`else
    check("int_e3", {31'd0, m_int_o}, 32'd0);
    xfer(32'h0100_0003, 1'b0, 32'h0, q);
    check("stat_rd", q, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
